// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: memory-mapped four-digit seven-segment scan controller.
// The CPU writes a 16-bit hex value (DATA) and a control word (CTRL); the
// block multiplexes the four digits with a programmable slot length and a
// one-cycle blank at the start of every slot to suppress ghosting.
module seg_display_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic        bus_addr,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        bus_rvalid,
  output logic [3:0]  segan_en,
  output logic [7:0]  segans
);

  localparam int unsigned     CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Active-low segment pattern (a..g in bits 0..6) for one hex nibble.
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  // Registers; CTRL[15:8] reads as zero, so only the low byte is stored
  logic [15:0]      data_q, data_d;
  logic [7:0]       ctrl_q, ctrl_d;
  // Read pipeline: snapshot stage, then the visible read port
  logic             rd_pend_q, rd_pend_d;
  logic [15:0]      rd_stage_q, rd_stage_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  // Display outputs
  logic [3:0]       en_q, en_d;
  logic [7:0]       seg_q, seg_d;

  logic [15:0]      reg_rd;
  logic [3:0]       nib;
  logic [3:0]       en_mask;
  logic [3:0]       dp_mask;

  // Slot counter and digit index: the digit advances on the last cycle of a slot.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    cnt_d = cnt_q + CNT_W'(1);
    dig_d = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end
  end

  // Register writes; CTRL keeps only its defined low byte.
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (bus_we) begin
      if (bus_addr) ctrl_d = bus_wdata[7:0];
      else          data_d = bus_wdata;
    end
  end

  // Reads snapshot the register at the request edge (so a simultaneous write
  // returns the old value) and present it one edge later.
  always_comb begin
    reg_rd     = bus_addr ? {8'h00, ctrl_q} : data_q;
    rd_pend_d  = bus_re;
    rd_stage_d = bus_re ? reg_rd : rd_stage_q;
    rvalid_d   = rd_pend_q;
    rdata_d    = rd_pend_q ? rd_stage_q : rdata_q;
  end

  // Display decode from the current scan position and register contents.
  always_comb begin
    en_mask = ctrl_q[3:0];
    dp_mask = ctrl_q[7:4];
    nib     = data_q[{dig_q, 2'b00} +: 4];
    en_d    = 4'hF;
    seg_d   = 8'hFF;
    if ((cnt_q != '0) && en_mask[dig_q]) begin
      en_d  = ~(4'b0001 << dig_q);
      seg_d = {~dp_mask[dig_q], hex_seg(nib)};
    end
  end

  // All state; the asynchronous reset also drops any read or scan in flight.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      cnt_q      <= '0;
      dig_q      <= 2'd0;
      data_q     <= 16'h0000;
      ctrl_q     <= 8'h0F;
      rd_pend_q  <= 1'b0;
      rd_stage_q <= 16'h0000;
      rdata_q    <= 16'h0000;
      rvalid_q   <= 1'b0;
      en_q       <= 4'hF;
      seg_q      <= 8'hFF;
    end else begin
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      rd_pend_q  <= rd_pend_d;
      rd_stage_q <= rd_stage_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      en_q       <= en_d;
      seg_q      <= seg_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign segan_en   = en_q;
  assign segans     = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: two instances (slot lengths 4 and 2) share the
// bus; display outputs are checked cycle by cycle from hand-derived tables,
// reads through an expected-value queue.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_we, bus_re, bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] rdata4, rdata2;
  logic        rvalid4, rvalid2;
  logic [3:0]  en4, en2;
  logic [7:0]  seg4, seg2;

  always #5 clk = ~clk;

  seg_display_ctrl #(.SCAN_DIV(4)) u4 (
    .clk(clk), .reset(reset), .bus_we(bus_we), .bus_re(bus_re),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata4),
    .bus_rvalid(rvalid4), .segan_en(en4), .segans(seg4)
  );

  seg_display_ctrl #(.SCAN_DIV(2)) u2 (
    .clk(clk), .reset(reset), .bus_we(bus_we), .bus_re(bus_re),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata2),
    .bus_rvalid(rvalid2), .segan_en(en2), .segans(seg2)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic        addr;
    logic [15:0] wdata;
    logic [3:0]  en;
    logic [7:0]  seg;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] val;
  } rd_exp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  rd_exp_t     sb[$];
  vec_t        vq[$];
  logic [15:0] sh_data, sh_ctrl;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t vec(input logic we, input logic re, input logic addr,
                               input logic [15:0] wd, input logic [3:0] en,
                               input logic [7:0] seg);
    vec_t r;
    r.we = we; r.re = re; r.addr = addr; r.wdata = wd; r.en = en; r.seg = seg;
    return r;
  endfunction

  // Drive one bus cycle, take the edge, then compare the read port.
  task automatic step(input logic we, input logic re, input logic addr, input logic [15:0] wd);
    rd_exp_t e;
    bus_we = we; bus_re = re; bus_addr = addr; bus_wdata = wd;
    if (re) begin
      e.due = cyc + 2;
      e.val = addr ? sh_ctrl : sh_data;
      sb.push_back(e);
    end
    if (we) begin
      if (addr) sh_ctrl = {8'h00, wd[7:0]};
      else      sh_data = wd;
    end
    @(posedge clk);
    cyc++;
    #1;
    bus_we = 1'b0; bus_re = 1'b0; bus_addr = 1'b0; bus_wdata = 16'h0000;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("rvalid", {15'd0, rvalid4}, 16'd1);
      check("rdata", rdata4, sb[0].val);
      sb.delete(0);
    end else begin
      check("rvalid_idle", {15'd0, rvalid4}, 16'd0);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    sb.delete();
    sh_data = 16'h0000;
    sh_ctrl = 16'h000F;
    repeat (2) @(posedge clk);
    #1;
    check("rst_en4", {12'd0, en4}, 16'h000F);
    check("rst_seg4", {8'd0, seg4}, 16'h00FF);
    check("rst_en2", {12'd0, en2}, 16'h000F);
    check("rst_rvalid", {15'd0, rvalid4}, 16'd0);
    check("rst_rdata", rdata4, 16'h0000);
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic run_vq(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].we, vq[i].re, vq[i].addr, vq[i].wdata);
      check($sformatf("%s[%0d].en", name, i), {12'd0, en4}, {12'd0, vq[i].en});
      check($sformatf("%s[%0d].seg", name, i), {8'd0, seg4}, {8'd0, vq[i].seg});
    end
  endtask

  task automatic push_n(input int n, input logic [3:0] en, input logic [7:0] seg);
    for (int i = 0; i < n; i++) vq.push_back(vec(1'b0, 1'b0, 1'b0, 16'h0000, en, seg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus_we = 1'b0; bus_re = 1'b0; bus_addr = 1'b0; bus_wdata = 16'h0000;

    // Startup: blank, digit0 three cycles, blank, digit1 ...; slot-2 instance
    // alternates blank / lit and wraps 3 -> 0 without an extra blank.
    apply_reset();
    vq.delete();
    push_n(1, 4'hF, 8'hFF); push_n(3, 4'hE, 8'hC0);
    push_n(1, 4'hF, 8'hFF); push_n(3, 4'hD, 8'hC0);
    push_n(1, 4'hF, 8'hFF); push_n(1, 4'hB, 8'hC0);
    for (int i = 0; i < vq.size(); i++) begin
      int k;
      logic [3:0] e2;
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      check($sformatf("start[%0d].en", i), {12'd0, en4}, {12'd0, vq[i].en});
      check($sformatf("start[%0d].seg", i), {8'd0, seg4}, {8'd0, vq[i].seg});
      k = i + 1;
      e2 = (k % 2 == 1) ? 4'hF : ~(4'b0001 << ((k / 2 - 1) % 4));
      check($sformatf("div2[%0d].en", i), {12'd0, en2}, {12'd0, e2});
      check($sformatf("div2[%0d].seg", i), {8'd0, seg2}, (k % 2 == 1) ? 16'h00FF : 16'h00C0);
    end

    // DATA = 3A5F over one full refresh and into the next.
    apply_reset();
    vq.delete();
    vq.push_back(vec(1'b1, 1'b0, 1'b0, 16'h3A5F, 4'hF, 8'hFF));
    push_n(3, 4'hE, 8'h8E); push_n(1, 4'hF, 8'hFF);
    push_n(3, 4'hD, 8'h92); push_n(1, 4'hF, 8'hFF);
    push_n(3, 4'hB, 8'h88); push_n(1, 4'hF, 8'hFF);
    push_n(3, 4'h7, 8'hB0); push_n(1, 4'hF, 8'hFF);
    push_n(1, 4'hE, 8'h8E);
    run_vq("refresh");

    // CTRL enable/dp masks, then a DATA write landing while digit1 is lit.
    apply_reset();
    vq.delete();
    vq.push_back(vec(1'b1, 1'b0, 1'b1, 16'h0025, 4'hF, 8'hFF));
    push_n(3, 4'hE, 8'hC0); push_n(4, 4'hF, 8'hFF);
    push_n(1, 4'hF, 8'hFF); push_n(3, 4'hB, 8'hC0);
    push_n(4, 4'hF, 8'hFF);
    vq.push_back(vec(1'b1, 1'b0, 1'b1, 16'h0023, 4'hF, 8'hFF));
    push_n(3, 4'hE, 8'hC0); push_n(1, 4'hF, 8'hFF);
    vq.push_back(vec(1'b1, 1'b0, 1'b0, 16'h0070, 4'hD, 8'h40));
    push_n(2, 4'hD, 8'h78);
    run_vq("ctrl");

    // Bus: read-during-write, CTRL masking, back-to-back reads, rdata hold.
    apply_reset();
    step(1'b1, 1'b0, 1'b0, 16'h1234);
    step(1'b1, 1'b1, 1'b0, 16'hBEEF);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("rdata_hold", rdata4, 16'hBEEF);

    // Asynchronous reset mid-slot with digit2 lit and a read in flight.
    apply_reset();
    step(1'b1, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    repeat (7) step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    check("mid_en", {12'd0, en4}, 16'h000B);
    check("mid_seg", {8'd0, seg4}, 16'h008E);
    #2;
    reset = 1'b0;
    #1;
    check("async_en", {12'd0, en4}, 16'h000F);
    check("async_seg", {8'd0, seg4}, 16'h00FF);
    check("async_rdata", rdata4, 16'h0000);
    sb.delete();
    sh_data = 16'h0000;
    sh_ctrl = 16'h000F;
    repeat (2) @(posedge clk);
    #1;
    check("hold_rvalid", {15'd0, rvalid4}, 16'd0);
    reset = 1'b1;
    cyc = 0;
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    check("restart_blank", {12'd0, en4}, 16'h000F);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("restart_en", {12'd0, en4}, 16'h000E);
    check("restart_seg", {8'd0, seg4}, 16'h00C0);

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
